// File: rtl/clint_pkg.sv
// Shared CLINT constants, widths and arbiter FSM encoding.
package clint_pkg;
    localparam int OFF_W  = 16;
    localparam int DATA_W = 32;

    localparam logic [OFF_W-1:0] MSIP_BASE     = 16'h0000;
    localparam logic [OFF_W-1:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [OFF_W-1:0] MTIME_LO      = 16'hBFF8;
    localparam logic [OFF_W-1:0] MTIME_HI      = 16'hBFFC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Pointer width that stays legal for a single requester.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request at or above ptr, wrapping.
module rr_arbiter
    import clint_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PW    = ptr_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt
);
    logic found;

    // Outer loop walks priority order from ptr; inner loop keeps all indices constant.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && req[j] && (((int'(ptr) + k) % N_REQ) == j)) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/clint_arbiter.sv
// Shares one CLINT register port among N_REQ requesters: grant, issue, respond.
module clint_arbiter
    import clint_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ-1:0]        i_we,
    input  logic [OFF_W*N_REQ-1:0]  i_offset,
    input  logic [DATA_W*N_REQ-1:0] i_wdata,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [N_REQ-1:0]        o_rvalid,
    output logic [DATA_W-1:0]       o_rdata,
    output logic [OFF_W-1:0]        o_offset,
    output logic                    o_we,
    output logic [DATA_W-1:0]       o_wdata,
    input  logic [DATA_W-1:0]       i_rdata
);
    localparam int PW = ptr_w(N_REQ);

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win;
    logic [OFF_W-1:0]  lat_off;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;

    logic [N_REQ-1:0]  arb_gnt;
    logic [PW-1:0]     arb_idx;
    logic [PW-1:0]     ptr_nxt;
    logic              sel_we;
    logic [OFF_W-1:0]  sel_off;
    logic [DATA_W-1:0] sel_wdata;

    rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr (
        .req (i_req),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    // Encode the one-hot winner and mux its command fields.
    always_comb begin
        arb_idx   = '0;
        sel_we    = 1'b0;
        sel_off   = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                arb_idx   = PW'(i);
                sel_we    = i_we[i];
                sel_off   = i_offset[i*OFF_W +: OFF_W];
                sel_wdata = i_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_nxt = (arb_idx == PW'(N_REQ-1)) ? '0 : arb_idx + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            win       <= '0;
            lat_off   <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|i_req) begin
                        state     <= ST_ISSUE;
                        win       <= arb_idx;
                        ptr       <= ptr_nxt;
                        lat_we    <= sel_we;
                        lat_off   <= sel_off;
                        lat_wdata <= sel_wdata;
                    end
                end
                ST_ISSUE: state <= ST_RESP;
                ST_RESP:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // RST gates every output so an in-flight access is dropped on the reset cycle.
    assign o_gnt    = (state == ST_IDLE && !RST) ? arb_gnt : '0;
    assign o_we     = (state == ST_ISSUE) && lat_we && !RST;
    assign o_offset = RST ? '0 : lat_off;
    assign o_wdata  = RST ? '0 : lat_wdata;
    assign o_rdata  = (state == ST_RESP && !RST) ? i_rdata : '0;

    always_comb begin
        o_rvalid = '0;
        for (int i = 0; i < N_REQ; i++)
            o_rvalid[i] = (state == ST_RESP) && !RST && (win == PW'(i));
    end
endmodule

// File: tb/tb_clint_arbiter.sv
// Scoreboard bench: two-requester arbiter against a CLINT model, plus a 4-way pointer check.
module tb_clint_arbiter;
    import clint_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    always #5 CLK = ~CLK;

    // N_REQ = 2 instance
    logic [1:0]  req2, we2, gnt2, rv2;
    logic [31:0] off2;
    logic [63:0] wd2;
    logic [31:0] ordata2, ird2, owd2;
    logic [15:0] ooff2;
    logic        owe2;

    clint_arbiter #(.N_REQ(2)) dut (
        .CLK(CLK), .RST(RST), .i_req(req2), .i_we(we2), .i_offset(off2), .i_wdata(wd2),
        .o_gnt(gnt2), .o_rvalid(rv2), .o_rdata(ordata2), .o_offset(ooff2), .o_we(owe2),
        .o_wdata(owd2), .i_rdata(ird2)
    );

    // N_REQ = 4 instance, used for pointer wrap only
    logic [3:0]   req4, gnt4, rv4;
    logic [3:0]   we4  = '0;
    logic [63:0]  off4 = '0;
    logic [127:0] wd4  = '0;
    logic [31:0]  ordata4, owd4;
    logic [31:0]  ird4 = 32'hA5A5_0000;
    logic [15:0]  ooff4;
    logic         owe4;

    clint_arbiter #(.N_REQ(4)) dut4 (
        .CLK(CLK), .RST(RST), .i_req(req4), .i_we(we4), .i_offset(off4), .i_wdata(wd4),
        .o_gnt(gnt4), .o_rvalid(rv4), .o_rdata(ordata4), .o_offset(ooff4), .o_we(owe4),
        .o_wdata(owd4), .i_rdata(ird4)
    );

    // CLINT model: registered read data, writes land at the clock edge.
    logic [31:0] msip0    = '0;
    logic [63:0] mtimecmp = '0;
    logic [63:0] mtime    = '0;
    logic        mt_ld    = 1'b0;
    logic [31:0] mt_val   = '0;

    always @(posedge CLK) begin
        if (mt_ld) mtime <= {32'b0, mt_val};
        else       mtime <= mtime + 64'd1;
        if (owe2) begin
            case (ooff2)
                MSIP_BASE:     msip0          <= owd2;
                MTIMECMP_BASE: mtimecmp[31:0] <= owd2;
                16'h4004:      mtimecmp[63:32] <= owd2;
                default: ;
            endcase
        end
        case (ooff2)
            MSIP_BASE:     ird2 <= msip0;
            MTIMECMP_BASE: ird2 <= mtimecmp[31:0];
            16'h4004:      ird2 <= mtimecmp[63:32];
            MTIME_LO:      ird2 <= mtime[31:0];
            MTIME_HI:      ird2 <= mtime[63:32];
            default:       ird2 <= '0;
        endcase
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          id;
        logic        we;
        logic [15:0] off;
        logic [31:0] wdata;
        logic        rd_chk;
        logic [31:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;

    function automatic txn_t mk(input int id, input logic we, input logic [15:0] off,
                                input logic [31:0] wdata, input logic rd_chk,
                                input logic [31:0] rdata);
        txn_t t;
        t.id = id; t.we = we; t.off = off; t.wdata = wdata; t.rd_chk = rd_chk; t.rdata = rdata;
        return t;
    endfunction

    int cyc      = 0;
    int stage    = 0;
    int gnt_cnt  = 0;
    int done_cnt = 0;
    int last_gnt = -1;
    bit chk_gap  = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: walks IDLE -> ISSUE -> RESP for each popped transaction.
    always @(negedge CLK) begin
        if (RST) begin
            chk("rst_gnt",    gnt2, 0);
            chk("rst_rvalid", rv2, 0);
            chk("rst_we",     owe2, 0);
            chk("rst_rdata",  ordata2, 0);
            stage = 0;
        end else begin
            case (stage)
                0: begin
                    if (gnt2 != 2'b00) begin
                        if (exp_q.size() == 0) begin
                            chk("gnt_unexpected", gnt2, 0);
                        end else begin
                            cur = exp_q.pop_front();
                            chk("gnt", gnt2, 64'd1 << cur.id);
                            chk("gnt_rvalid", rv2, 0);
                            if (chk_gap && last_gnt >= 0) chk("gnt_gap", cyc - last_gnt, 3);
                            last_gnt = cyc;
                            gnt_cnt++;
                            stage = 1;
                        end
                    end else begin
                        chk("idle_we",     owe2, 0);
                        chk("idle_rvalid", rv2, 0);
                    end
                end
                1: begin
                    chk("iss_gnt",    gnt2, 0);
                    chk("iss_we",     owe2, cur.we);
                    chk("iss_off",    ooff2, cur.off);
                    chk("iss_rvalid", rv2, 0);
                    if (cur.we) chk("iss_wdata", owd2, cur.wdata);
                    stage = 2;
                end
                default: begin
                    chk("rsp_rvalid", rv2, 64'd1 << cur.id);
                    chk("rsp_gnt",    gnt2, 0);
                    chk("rsp_we",     owe2, 0);
                    if (cur.rd_chk) chk("rsp_rdata", ordata2, cur.rdata);
                    done_cnt++;
                    stage = 0;
                end
            endcase
        end
    end

    task automatic wait_gnt(input int target);
        for (int i = 0; i < 80 && gnt_cnt < target; i++) begin
            @(negedge CLK); #1;
        end
        if (gnt_cnt < target) chk("gnt_timeout", gnt_cnt, target);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 80 && done_cnt < target; i++) begin
            @(negedge CLK); #1;
        end
        if (done_cnt < target) chk("done_timeout", done_cnt, target);
    endtask

    task automatic drive(input int id, input logic we, input logic [15:0] off, input logic [31:0] wd);
        we2[id]          = we;
        off2[id*16 +: 16] = off;
        wd2[id*32 +: 32]  = wd;
        req2[id]         = 1'b1;
    endtask

    task automatic access(input int id, input logic we, input logic [15:0] off,
                          input logic [31:0] wd, input logic rd_chk, input logic [31:0] rd);
        int g, d;
        g = gnt_cnt + 1;
        d = done_cnt + 1;
        exp_q.push_back(mk(id, we, off, wd, rd_chk, rd));
        @(posedge CLK); #1;
        mt_ld = 1'b0;
        drive(id, we, off, wd);
        wait_gnt(g);
        @(posedge CLK); #1;
        req2[id] = 1'b0;
        wait_done(d);
    endtask

    task automatic gnt4_step(input logic [3:0] req, input int exp_id);
        @(posedge CLK); #1;
        req4 = req;
        @(negedge CLK);
        chk("gnt4", gnt4, 64'd1 << exp_id);
        @(posedge CLK); #1;
        req4 = '0;
        @(negedge CLK);
        chk("gnt4_issue", gnt4, 0);
        @(negedge CLK);
        chk("rvalid4", rv4, 64'd1 << exp_id);
    endtask

    initial begin
        int base;
        RST  = 1'b1;
        req2 = '0; we2 = '0; wd2 = '0;
        off2 = {MTIME_HI, MTIME_LO};
        req4 = '0;

        // Contention from reset: both held, grants must alternate with a 3-cycle gap.
        for (int i = 0; i < 20; i++)
            exp_q.push_back(mk(i % 2, 1'b0, (i % 2) ? MTIME_HI : MTIME_LO, 32'h0, 1'b0, 32'h0));
        req2 = 2'b11;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        chk_gap = 1'b1; last_gnt = -1;
        @(negedge CLK);
        chk("post_rst_off",    ooff2, 0);
        chk("post_rst_wdata",  owd2, 0);
        chk("post_rst_we",     owe2, 0);
        chk("post_rst_rvalid", rv2, 0);
        wait_gnt(20);
        @(posedge CLK); #1;
        req2 = '0;
        wait_done(20);
        chk_gap = 1'b0;

        // Single read of mtime: 100 at the grant cycle, 101 when the CLINT samples it.
        @(posedge CLK); #1;
        mt_ld = 1'b1; mt_val = 32'd100;
        access(0, 1'b0, MTIME_LO, 32'h0, 1'b1, 32'd101);

        // Write mtimecmp via req1, read it back via req0.
        access(1, 1'b1, MTIMECMP_BASE, 32'h0000_1234, 1'b0, 32'h0);
        chk("model_mtimecmp", mtimecmp[31:0], 32'h0000_1234);
        access(0, 1'b0, MTIMECMP_BASE, 32'h0, 1'b1, 32'h0000_1234);

        // Back-to-back: req0 held for three accesses.
        base = gnt_cnt;
        for (int i = 0; i < 3; i++)
            exp_q.push_back(mk(0, 1'b0, MTIME_HI, 32'h0, 1'b1, 32'h0));
        chk_gap = 1'b1; last_gnt = -1;
        @(posedge CLK); #1;
        drive(0, 1'b0, MTIME_HI, 32'h0);
        wait_gnt(base + 3);
        @(posedge CLK); #1;
        req2 = '0;
        wait_done(base + 3);
        chk_gap = 1'b0;

        // Reset during ISSUE of an msip0 write: nothing may reach the CLINT.
        base = gnt_cnt;
        exp_q.push_back(mk(0, 1'b1, MSIP_BASE, 32'h1, 1'b0, 32'h0));
        @(posedge CLK); #1;
        drive(0, 1'b1, MSIP_BASE, 32'h1);
        wait_gnt(base + 1);
        @(posedge CLK); #1;
        req2 = '0;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("abort_msip0", msip0, 0);

        // Pointer back at 0: both requesting, req0 wins and reads unchanged msip0.
        base = gnt_cnt;
        exp_q.push_back(mk(0, 1'b0, MSIP_BASE, 32'h0, 1'b1, 32'h0));
        exp_q.push_back(mk(1, 1'b0, MTIMECMP_BASE, 32'h0, 1'b1, 32'h0000_1234));
        drive(0, 1'b0, MSIP_BASE, 32'h0);
        drive(1, 1'b0, MTIMECMP_BASE, 32'h0);
        wait_gnt(base + 1);
        @(posedge CLK); #1;
        req2[0] = 1'b0;
        wait_gnt(base + 2);
        @(posedge CLK); #1;
        req2[1] = 1'b0;
        wait_done(done_cnt + 1);
        chk("queue_empty", exp_q.size(), 0);

        // 4-way wrap: grant 3 moves pointer to 0, then to 1.
        gnt4_step(4'b1000, 3);
        gnt4_step(4'b0101, 0);
        gnt4_step(4'b0110, 1);

        repeat (3) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/clint_arbiter.md
CLINT_ARBITER -- requirements
Module: clint_arbiter

Interface
REQ-001 Parameter: N_REQ, 2, number of requesters sharing the CLINT register port (legal range 1..8).
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 i_req  input  N_REQ  per-requester access request, held until granted.
REQ-006 i_we  input  N_REQ  per-requester write enable (1 = write, 0 = read).
REQ-007 i_offset  input  16*N_REQ  per-requester CLINT offset, slice k = bits [16k+15:16k].
REQ-008 i_wdata  input  32*N_REQ  per-requester write data, slice k = bits [32k+31:32k].
REQ-009 o_gnt  output  N_REQ  one-hot grant pulse, one cycle; command is captured on this cycle.
REQ-010 o_rvalid  output  N_REQ  one-hot completion pulse, one cycle; marks read data valid or write done.
REQ-011 o_rdata  output  32  shared response data, valid only while some o_rvalid bit is high.
REQ-012 o_offset  output  16  offset driven to CLINT.
REQ-013 o_we  output  1  write strobe to CLINT.
REQ-014 o_wdata  output  32  write data to CLINT.
REQ-015 i_rdata  input  32  CLINT read data, registered in CLINT, valid one cycle after o_offset is presented.

Function
REQ-016 FSM states: IDLE, ISSUE, RESP; IDLE->ISSUE when any i_req bit is high, ISSUE->RESP unconditionally, RESP->IDLE unconditionally.
REQ-017 In IDLE with any request: winner chosen combinationally by round-robin; o_gnt[winner]=1 that cycle; i_we/i_offset/i_wdata of winner latched at the edge.
REQ-018 Round-robin: search starts at priority pointer p, ascending with wrap N_REQ-1 -> 0; after granting k, p <= (k+1) mod N_REQ.
REQ-019 ISSUE: latched offset and wdata on o_offset/o_wdata; o_we = latched we for exactly this one cycle.
REQ-020 RESP: o_rdata = i_rdata; o_rvalid[winner]=1 for one cycle, for reads and writes alike.
REQ-021 Write in ISSUE: o_rdata in RESP carries the pre-write CLINT value; requesters ignore it.
REQ-022 Latency: gnt at cycle T, CLINT access at T+1, rvalid at T+2; next grant no earlier than T+3; peak throughput one access per 3 cycles.
REQ-023 o_gnt is zero outside IDLE; i_req changes during ISSUE/RESP are ignored.
REQ-024 Requester that keeps i_req high after its rvalid is treated as a new request.
REQ-025 o_we = 0 in IDLE and RESP; o_offset/o_wdata hold last latched value outside ISSUE.
REQ-026 N_REQ = 1: pointer is constant 0; requester granted whenever in IDLE.

Reset
REQ-027 RST high: state <= IDLE, p <= 0, latched offset <= 0, latched wdata <= 0, latched we <= 0, winner <= 0.
REQ-028 Under and immediately after reset: o_gnt=0, o_rvalid=0, o_we=0, o_offset=0, o_wdata=0, o_rdata=0.
REQ-029 Reset during ISSUE or RESP aborts the access: no o_rvalid is issued; a write in ISSUE on the reset cycle is suppressed (o_we=0).

Structure
REQ-030 Package clint_pkg: CLINT offset constants (MSIP_BASE 16'h0000, MTIMECMP_BASE 16'h4000, MTIME_LO 16'hBFF8, MTIME_HI 16'hBFFC), data/offset widths, FSM state encoding.
REQ-031 Sub-module rr_arbiter (N_REQ requests, pointer in, one-hot grant out, combinational) is instantiated once; FSM, latches and pointer update stay in clint_arbiter.

Verification
REQ-032 Single read: N_REQ=2, req0 read offset 16'hBFF8 with CLINT mtime=100 -> gnt0 at T, o_offset=BFF8 at T+1, rvalid0 at T+2 with o_rdata=101 (mtime value at CLINT sample).
REQ-033 Single write: req1 write 16'h4000 data 32'h0000_1234 -> o_we=1 only at T+1 with matching offset/data; rvalid1 at T+2; a later read of 16'h4000 returns 32'h0000_1234.
REQ-034 Contention: req0 and req1 held high continuously from reset -> grants alternate 0,1,0,1 every 3 cycles; no starvation over 20 grants.
REQ-035 Pointer wrap: N_REQ=4, only req3 then only req0 -> p goes 0->0 after req3 grant (3+1 mod 4); req0 granted next.
REQ-036 Reset mid-access: assert RST in ISSUE of a write to 16'h0000 data 1 -> o_we stays 0, no rvalid, msip0 unchanged, FSM in IDLE with p=0 after release.
REQ-037 Back-to-back same requester: req0 held high for 3 accesses -> gnt0 at T, T+3, T+6; rvalid0 at T+2, T+5, T+8.
